// File: rtl/regbank_sequencer.sv
// rtl/regbank_sequencer.sv - sequences the 16x64 register bank for one execution unit
// One micro-instruction in flight: read, load, exec handshake with timeout, writeback.
module regbank_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [17:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             exec_start,
  input  logic             exec_done,
  output logic             regwen,
  output logic [3:0]       selwreg,
  output logic [1:0]       endreg,
  output logic [3:0]       seloutA,
  output logic [3:0]       seloutB,
  output logic             cnstA,
  output logic             cnstB,
  output logic             enrregA,
  output logic             enrregB,
  output logic             err,
  input  logic             clr_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LOADW, S_EXEC, S_WRITE} state_t;

  localparam logic [1:0]       K_NOP   = 2'b00;
  localparam logic [1:0]       K_READ  = 2'b01;
  localparam logic [1:0]       K_RMW   = 2'b10;
  localparam logic [15:0]      T_LAST  = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t      state;
  logic [1:0]  ir_kind;
  logic [3:0]  ir_dst;
  logic [1:0]  ir_endreg;
  logic [15:0] tcnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ir_kind     <= 2'b00;
      ir_dst      <= 4'd0;
      ir_endreg   <= 2'b00;
      tcnt        <= 16'd0;
      instr_ready <= 1'b0;
      exec_start  <= 1'b0;
      regwen      <= 1'b0;
      selwreg     <= 4'd0;
      endreg      <= 2'b00;
      seloutA     <= 4'd0;
      seloutB     <= 4'd0;
      cnstA       <= 1'b0;
      cnstB       <= 1'b0;
      enrregA     <= 1'b0;
      enrregB     <= 1'b0;
      err         <= 1'b0;
      retired     <= '0;
    end else begin
      enrregA    <= 1'b0;
      enrregB    <= 1'b0;
      exec_start <= 1'b0;
      regwen     <= 1'b0;
      // A timeout in the same cycle overrides this clear further down.
      if (clr_err) err <= 1'b0;

      case (state)
        S_IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            ir_kind   <= instr[17:16];
            ir_dst    <= instr[15:12];
            ir_endreg <= instr[3:2];
            case (instr[17:16])
              K_NOP: retired <= retired + CNT_ONE;
              K_READ, K_RMW: begin
                instr_ready <= 1'b0;
                seloutA     <= instr[11:8];
                seloutB     <= instr[7:4];
                cnstA       <= instr[1];
                cnstB       <= instr[0];
                enrregA     <= 1'b1;
                enrregB     <= 1'b1;
                state       <= S_READ;
              end
              default: begin
                instr_ready <= 1'b0;
                tcnt        <= 16'd0;
                state       <= S_EXEC;
              end
            endcase
          end
        end
        S_READ: state <= S_LOADW;
        S_LOADW: begin
          exec_start <= 1'b1;
          tcnt       <= 16'd0;
          state      <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_done) begin
            if (ir_kind == K_READ) begin
              retired     <= retired + CNT_ONE;
              instr_ready <= 1'b1;
              state       <= S_IDLE;
            end else begin
              regwen  <= 1'b1;
              selwreg <= ir_dst;
              endreg  <= ir_endreg;
              state   <= S_WRITE;
            end
          end else if (tcnt == T_LAST) begin
            err         <= 1'b1;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_WRITE: begin
          retired     <= retired + CNT_ONE;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
